mem_arbiter: RTL and testbench

//  Shares one unified 32-bit-word main memory between the instruction cache (read-only, 128-bit block refills)
//  and the data cache (32-bit block read/write-back). Sits between both caches and the memory model.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 49 ++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter: FSM states, requester IDs,
// region bases and the instruction block size.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    typedef enum logic {
        ReqData,
        ReqInst
    } req_id_e;

    localparam int unsigned IBASE_DEFAULT    = 0;
    localparam int unsigned DBASE_DEFAULT    = 256;
    localparam int unsigned BEATS_PER_IBLOCK = 4;

    function automatic req_id_e other_req(input req_id_e id);
        if (id == ReqData) begin
            return ReqInst;
        end
        return ReqData;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic with a last-grant pointer. MEM_ARB_DPRIO_EN selects fixed data priority;
// otherwise round-robin.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    d_req,
    input  logic    i_req,
    input  logic    grant_en,
    output logic    grant_valid,
    output req_id_e grant_id
);

    assign grant_valid = d_req | i_req;

`ifdef MEM_ARB_DPRIO_EN
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, grant_en};

    always_comb begin
        grant_id = ReqData;
        if (!d_req && i_req) begin
            grant_id = ReqInst;
        end
    end
`else
    // Holds the requester that wins the next tie; flips to the other side after every grant.
    req_id_e prio_q;

    always_comb begin
        grant_id = ReqData;
        if (d_req && i_req) begin
            grant_id = prio_q;
        end else if (i_req) begin
            grant_id = ReqInst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= ReqData;
        end else if (grant_en && grant_valid) begin
            prio_q <= other_req(grant_id);
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one word-addressed memory between the I-cache (4-beat block refill) and the D-cache.
// Define MEM_ARB_DPRIO_EN for fixed data priority instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_AW = 9,
    parameter int unsigned IBASE  = IBASE_DEFAULT,
    parameter int unsigned DBASE  = DBASE_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [5:0]        D_ADDRESS,
    input  logic [31:0]       D_WRITEDATA,
    output logic [31:0]       D_READDATA,
    output logic              D_BUSYWAIT,
    input  logic              I_READ,
    input  logic [5:0]        I_ADDRESS,
    output logic [127:0]      I_READDATA,
    output logic              I_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [MEM_AW-1:0] MEM_ADDRESS,
    output logic [31:0]       MEM_WRITEDATA,
    input  logic [31:0]       MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    localparam logic [MEM_AW-1:0] IBASE_W   = MEM_AW'(IBASE);
    localparam logic [MEM_AW-1:0] DBASE_W   = MEM_AW'(DBASE);
    localparam logic [1:0]        LAST_BEAT = 2'(BEATS_PER_IBLOCK - 1);

    state_e                               state_q;
    req_id_e                              owner_q;
    logic    [1:0]                        beat_q;
    logic    [5:0]                        iblk_q;
    logic                                 write_q;
    logic    [31:0]                       dword_q;
    logic    [BEATS_PER_IBLOCK-1:0][31:0] ibuf_q;

    logic    d_req;
    logic    idle;
    logic    grant_valid;
    req_id_e grant_id;
    logic    d_done;
    logic    i_done;

    function automatic logic [MEM_AW-1:0] ibeat_addr(input logic [5:0] blk, input logic [1:0] beat);
        return IBASE_W + MEM_AW'({blk, beat});
    endfunction

    assign d_req  = D_READ | D_WRITE;
    assign idle   = (state_q == StIdle);
    assign d_done = (state_q == StResp) && (owner_q == ReqData);
    assign i_done = (state_q == StResp) && (owner_q == ReqInst) && (beat_q == LAST_BEAT);

    rr_arb2 u_arb (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .d_req      (d_req),
        .i_req      (I_READ),
        .grant_en   (idle),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= StIdle;
            owner_q       <= ReqData;
            beat_q        <= '0;
            iblk_q        <= '0;
            write_q       <= 1'b0;
            dword_q       <= '0;
            ibuf_q        <= '0;
            D_READDATA    <= '0;
            D_BUSYWAIT    <= 1'b0;
            I_READDATA    <= '0;
            I_BUSYWAIT    <= 1'b0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
        end else begin
            // Busy covers both the wait for grant and a transaction whose request was dropped.
            D_BUSYWAIT <= d_done ? 1'b0 : (D_BUSYWAIT | d_req);
            I_BUSYWAIT <= i_done ? 1'b0 : (I_BUSYWAIT | I_READ);

            unique case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        owner_q <= grant_id;
                        beat_q  <= '0;
                        state_q <= StIssue;
                        if (grant_id == ReqData) begin
                            write_q       <= D_WRITE;
                            MEM_READ      <= D_READ;
                            MEM_WRITE     <= D_WRITE;
                            MEM_ADDRESS   <= DBASE_W + MEM_AW'(D_ADDRESS);
                            MEM_WRITEDATA <= D_WRITEDATA;
                        end else begin
                            write_q     <= 1'b0;
                            iblk_q      <= I_ADDRESS;
                            MEM_READ    <= 1'b1;
                            MEM_WRITE   <= 1'b0;
                            MEM_ADDRESS <= ibeat_addr(I_ADDRESS, 2'd0);
                        end
                    end
                end
                StIssue: begin
                    if (MEM_BUSYWAIT) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (!MEM_BUSYWAIT) begin
                        if (owner_q == ReqInst) begin
                            ibuf_q[beat_q] <= MEM_READDATA;
                        end else begin
                            dword_q <= MEM_READDATA;
                        end
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    if ((owner_q == ReqInst) && (beat_q != LAST_BEAT)) begin
                        beat_q      <= beat_q + 2'd1;
                        MEM_READ    <= 1'b1;
                        MEM_ADDRESS <= ibeat_addr(iblk_q, beat_q + 2'd1);
                        state_q     <= StIssue;
                    end else begin
                        if (owner_q == ReqInst) begin
                            I_READDATA <= ibuf_q;
                        end else if (!write_q) begin
                            D_READDATA <= dword_q;
                        end
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: word memory model with programmable busy time,
// directed scenarios plus randomized traffic checked against a shadow memory.
module tb_mem_arbiter;

    localparam int unsigned MEM_AW = 9;
    localparam int unsigned IBASE  = 0;
    localparam int unsigned DBASE  = 256;
    localparam int          MAXW   = 400;

    logic              CLK           = 1'b0;
    logic              RESET_N       = 1'b1;
    logic              D_READ        = 1'b0;
    logic              D_WRITE       = 1'b0;
    logic [5:0]        D_ADDRESS     = '0;
    logic [31:0]       D_WRITEDATA   = '0;
    logic [31:0]       D_READDATA;
    logic              D_BUSYWAIT;
    logic              I_READ        = 1'b0;
    logic [5:0]        I_ADDRESS     = '0;
    logic [127:0]      I_READDATA;
    logic              I_BUSYWAIT;
    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [MEM_AW-1:0] MEM_ADDRESS;
    logic [31:0]       MEM_WRITEDATA;
    logic [31:0]       MEM_READDATA  = '0;
    logic              MEM_BUSYWAIT;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [512];

    mem_arbiter #(
        .MEM_AW(MEM_AW),
        .IBASE (IBASE),
        .DBASE (DBASE)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .D_READ       (D_READ),
        .D_WRITE      (D_WRITE),
        .D_ADDRESS    (D_ADDRESS),
        .D_WRITEDATA  (D_WRITEDATA),
        .D_READDATA   (D_READDATA),
        .D_BUSYWAIT   (D_BUSYWAIT),
        .I_READ       (I_READ),
        .I_ADDRESS    (I_ADDRESS),
        .I_READDATA   (I_READDATA),
        .I_BUSYWAIT   (I_BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory model: accepts a request one edge after seeing it, stays busy mem_lat cycles.
    logic [31:0]       mem [512];
    logic              mbusy  = 1'b0;
    logic              served = 1'b0;
    int                cnt    = 0;
    int                mem_lat = 2;
    logic [MEM_AW-1:0] cur_a  = '0;
    logic              cur_we = 1'b0;
    logic [31:0]       cur_wd = '0;
    logic              pl_en  = 1'b0;
    logic [8:0]        pl_addr = '0;
    logic [31:0]       pl_data = '0;
    logic [8:0]        log_addr [4096];
    logic              log_we   [4096];
    logic [31:0]       log_wd   [4096];
    longint            log_t    [4096];
    int                log_n    = 0;
    int                stab_err = 0;

    assign MEM_BUSYWAIT = mbusy;

    always @(posedge CLK) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (!RESET_N) begin
            mbusy  <= 1'b0;
            served <= 1'b0;
            cnt    <= 0;
        end else if (mbusy) begin
            if (!(MEM_READ | MEM_WRITE) || MEM_ADDRESS !== cur_a ||
                (cur_we && MEM_WRITEDATA !== cur_wd)) stab_err <= stab_err + 1;
            if (cnt <= 1) begin
                mbusy  <= 1'b0;
                served <= 1'b1;
                if (cur_we) mem[cur_a] <= cur_wd;
                else MEM_READDATA <= mem[cur_a];
            end
            cnt <= cnt - 1;
        end else if ((MEM_READ | MEM_WRITE) && !served) begin
            mbusy           <= 1'b1;
            cnt             <= mem_lat;
            cur_a           <= MEM_ADDRESS;
            cur_we          <= MEM_WRITE;
            cur_wd          <= MEM_WRITEDATA;
            log_addr[log_n] <= MEM_ADDRESS;
            log_we[log_n]   <= MEM_WRITE;
            log_wd[log_n]   <= MEM_WRITEDATA;
            log_t[log_n]    <= $time;
            log_n           <= log_n + 1;
        end else if (!(MEM_READ | MEM_WRITE)) begin
            served <= 1'b0;
        end
    end

    function automatic logic [8:0] dmap(input logic [5:0] a);
        return 9'(DBASE + int'(a));
    endfunction

    function automatic logic [8:0] imap(input logic [5:0] a, input int k);
        return 9'(IBASE + 4 * int'(a) + k);
    endfunction

    function automatic logic [127:0] exp_block(input logic [5:0] a);
        logic [127:0] v = '0;
        for (int k = 0; k < 4; k++) v[32*k +: 32] = ref_mem[imap(a, k)];
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [8:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en      = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic apply_reset();
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
    endtask

    // lat = edges from the request-sampling edge to the completion edge, -1 on timeout.
    task automatic do_data(input logic we, input logic [5:0] a, input logic [31:0] wd,
                           output int lat, output longint t_done);
        D_ADDRESS   = a;
        D_WRITEDATA = wd;
        D_WRITE     = we;
        D_READ      = !we;
        lat         = -1;
        for (int c = 1; c <= MAXW; c++) begin
            tick();
            if (!D_BUSYWAIT) begin
                lat = c - 1;
                break;
            end
        end
        t_done  = $time;
        D_READ  = 1'b0;
        D_WRITE = 1'b0;
    endtask

    task automatic do_inst(input logic [5:0] a, output int lat, output longint t_done);
        I_ADDRESS = a;
        I_READ    = 1'b1;
        lat       = -1;
        for (int c = 1; c <= MAXW; c++) begin
            tick();
            if (!I_BUSYWAIT) begin
                lat = c - 1;
                break;
            end
        end
        t_done = $time;
        I_READ = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({MEM_READ, MEM_WRITE, D_BUSYWAIT, I_BUSYWAIT} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000",
                     {MEM_READ, MEM_WRITE, D_BUSYWAIT, I_BUSYWAIT});
        end
        n_checks++;
        if (MEM_ADDRESS !== '0 || MEM_WRITEDATA !== '0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", MEM_ADDRESS, MEM_WRITEDATA);
        end
        n_checks++;
        if (D_READDATA !== '0 || I_READDATA !== '0) begin
            n_fail++;
            $display("FAIL reset_readdata: got d %h i %h want 0", D_READDATA, I_READDATA);
        end
    endtask

    task automatic test_data_read();
        int lat, base;
        longint t;
        mem_lat = 2;
        preload(9'd261, 32'hDEADBEEF);
        base = log_n;
        do_data(1'b0, 6'd5, 32'h0, lat, t);
        n_checks++;
        if (D_READDATA !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL dread_data: got %h want deadbeef", D_READDATA);
        end
        n_checks++;
        if (lat !== 3 + mem_lat) begin
            n_fail++;
            $display("FAIL dread_latency: got %0d want %0d", lat, 3 + mem_lat);
        end
        n_checks++;
        if (log_n - base !== 1 || log_addr[base] !== 9'd261 || log_we[base] !== 1'b0) begin
            n_fail++;
            $display("FAIL dread_access: got n %0d addr %0d we %b want 1 261 0",
                     log_n - base, log_addr[base], log_we[base]);
        end
    endtask

    task automatic test_inst_refill();
        int lat, base;
        longint t;
        mem_lat = 1;
        for (int k = 0; k < 4; k++) preload(9'(8 + k), 32'(8'h11 * (k + 1)));
        base = log_n;
        do_inst(6'd2, lat, t);
        n_checks++;
        if (I_READDATA !== 128'h00000044_00000033_00000022_00000011) begin
            n_fail++;
            $display("FAIL irefill_data: got %h want 00000044000000330000002200000011", I_READDATA);
        end
        n_checks++;
        if (log_n - base !== 4) begin
            n_fail++;
            $display("FAIL irefill_count: got %0d want 4", log_n - base);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (log_addr[base + k] !== 9'(8 + k)) begin
                n_fail++;
                $display("FAIL irefill_addr%0d: got %0d want %0d", k, log_addr[base + k], 8 + k);
            end
        end
        // The beat spacing exposes the one-cycle gap where MEM_READ drops between beats.
        for (int k = 1; k < 4; k++) begin
            n_checks++;
            if (log_t[base + k] - log_t[base + k - 1] !== longint'(10 * (3 + mem_lat))) begin
                n_fail++;
                $display("FAIL irefill_gap%0d: got %0d want %0d", k,
                         log_t[base + k] - log_t[base + k - 1], 10 * (3 + mem_lat));
            end
        end
        n_checks++;
        if (lat !== 4 * (3 + mem_lat)) begin
            n_fail++;
            $display("FAIL irefill_latency: got %0d want %0d", lat, 4 * (3 + mem_lat));
        end
    endtask

    task automatic test_arbitration();
        int lat_a, lat_b, lat_i, base, got_order, exp_order;
        longint t_a, t_b, t_i;
        logic [5:0] da, db, ia;
        logic [8:0] exp_seq [6];
        apply_reset();
        mem_lat = 1;
        da = 6'($urandom);
        db = 6'($urandom);
        ia = 6'($urandom);
        base = log_n;
        fork
            begin
                do_data(1'b0, da, 32'h0, lat_a, t_a);
                do_data(1'b0, db, 32'h0, lat_b, t_b);
            end
            do_inst(ia, lat_i, t_i);
        join
        got_order = (t_a < t_i && t_i < t_b) ? 1 : (t_a < t_b && t_b < t_i) ? 2 : 0;
`ifdef MEM_ARB_DPRIO_EN
        exp_order = 2;
        exp_seq[0] = dmap(da);
        exp_seq[1] = dmap(db);
        for (int k = 0; k < 4; k++) exp_seq[2 + k] = imap(ia, k);
`else
        exp_order = 1;
        exp_seq[0] = dmap(da);
        for (int k = 0; k < 4; k++) exp_seq[1 + k] = imap(ia, k);
        exp_seq[5] = dmap(db);
`endif
        n_checks++;
        if (got_order !== exp_order) begin
            n_fail++;
            $display("FAIL arb_order: got %0d want %0d (t_a %0d t_b %0d t_i %0d)",
                     got_order, exp_order, t_a, t_b, t_i);
        end
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (log_addr[base + k] !== exp_seq[k]) begin
                n_fail++;
                $display("FAIL arb_seq%0d: got %0d want %0d", k, log_addr[base + k], exp_seq[k]);
            end
        end
        n_checks++;
        if (D_READDATA !== ref_mem[dmap(db)] || I_READDATA !== exp_block(ia)) begin
            n_fail++;
            $display("FAIL arb_data: got d %h i %h want d %h i %h",
                     D_READDATA, I_READDATA, ref_mem[dmap(db)], exp_block(ia));
        end
    endtask

    task automatic test_write_during_burst();
        int lat_i, lat_d, base;
        longint t_i, t_d;
        logic [5:0] ia;
        logic [31:0] d_before;
        logic found;
        mem_lat = 2;
        ia = 6'($urandom);
        d_before = D_READDATA;
        base = log_n;
        found = 1'b0;
        t_d = 0;
        fork
            do_inst(ia, lat_i, t_i);
            begin
                for (int c = 0; c < MAXW && !found; c++) begin
                    if (MEM_READ && MEM_ADDRESS == imap(ia, 2)) found = 1'b1;
                    else tick();
                end
                if (found) do_data(1'b1, 6'd63, 32'hCAFEF00D, lat_d, t_d);
            end
        join
        ref_mem[319] = 32'hCAFEF00D;
        n_checks++;
        if (found !== 1'b1 || t_d <= t_i) begin
            n_fail++;
            $display("FAIL wburst_order: got found %b t_d %0d t_i %0d want found 1 t_d>t_i",
                     found, t_d, t_i);
        end
        n_checks++;
        if (log_n - base !== 5 || log_addr[base + 3] !== imap(ia, 3)) begin
            n_fail++;
            $display("FAIL wburst_seq: got n %0d addr3 %0d want 5 %0d",
                     log_n - base, log_addr[base + 3], imap(ia, 3));
        end
        n_checks++;
        if (log_addr[base + 4] !== 9'd319 || log_we[base + 4] !== 1'b1 ||
            log_wd[base + 4] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL wburst_write: got addr %0d we %b data %h want 319 1 cafef00d",
                     log_addr[base + 4], log_we[base + 4], log_wd[base + 4]);
        end
        n_checks++;
        if (D_READDATA !== d_before || I_READDATA !== exp_block(ia)) begin
            n_fail++;
            $display("FAIL wburst_readdata: got d %h i %h want d %h i %h",
                     D_READDATA, I_READDATA, d_before, exp_block(ia));
        end
        do_data(1'b0, 6'd63, 32'h0, lat_d, t_d);
        n_checks++;
        if (D_READDATA !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL wburst_readback: got %h want cafef00d", D_READDATA);
        end
    endtask

    task automatic test_reset_mid_burst();
        int lat, base;
        longint t;
        logic [5:0] ia, ib;
        logic found;
        mem_lat = 3;
        ia = 6'($urandom);
        I_ADDRESS = ia;
        I_READ = 1'b1;
        found = 1'b0;
        for (int c = 0; c < MAXW && !found; c++) begin
            if (MEM_READ && MEM_ADDRESS == imap(ia, 1)) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_beat1: got found %b want 1", found);
        end
        #2 RESET_N = 1'b0;
        #1;
        n_checks++;
        if ({MEM_READ, MEM_WRITE, D_BUSYWAIT, I_BUSYWAIT} !== 4'b0 || MEM_ADDRESS !== '0) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: got %b addr %h want 0000 0",
                     {MEM_READ, MEM_WRITE, D_BUSYWAIT, I_BUSYWAIT}, MEM_ADDRESS);
        end
        n_checks++;
        if (I_READDATA !== '0 || D_READDATA !== '0 || MEM_WRITEDATA !== '0) begin
            n_fail++;
            $display("FAIL rstmid_data: got i %h d %h w %h want 0",
                     I_READDATA, D_READDATA, MEM_WRITEDATA);
        end
        I_READ = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
        tick();
        ib = 6'($urandom);
        base = log_n;
        do_inst(ib, lat, t);
        n_checks++;
        if (log_n - base !== 4 || log_addr[base] !== imap(ib, 0)) begin
            n_fail++;
            $display("FAIL rstmid_restart: got n %0d addr %0d want 4 %0d",
                     log_n - base, log_addr[base], imap(ib, 0));
        end
        n_checks++;
        if (I_READDATA !== exp_block(ib) || lat !== 4 * (3 + mem_lat)) begin
            n_fail++;
            $display("FAIL rstmid_refill: got %h lat %0d want %h lat %0d",
                     I_READDATA, lat, exp_block(ib), 4 * (3 + mem_lat));
        end
    endtask

    task automatic test_backpressure();
        int lat;
        longint t;
        logic [5:0] ia, da;
        logic [31:0] wd;
        mem_lat = 5;
        ia = 6'($urandom);
        da = 6'($urandom);
        wd = $urandom;
        do_inst(ia, lat, t);
        n_checks++;
        if (lat !== 32 || I_READDATA !== exp_block(ia)) begin
            n_fail++;
            $display("FAIL bp_refill: got lat %0d data %h want 32 %h", lat, I_READDATA, exp_block(ia));
        end
        do_data(1'b1, da, wd, lat, t);
        ref_mem[dmap(da)] = wd;
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL bp_write_latency: got %0d want 8", lat);
        end
        n_checks++;
        if (stab_err !== 0) begin
            n_fail++;
            $display("FAIL bp_bus_stable: got %0d unstable edges want 0", stab_err);
        end
    endtask

    task automatic test_random();
        int lat, base, kind, exp_lat;
        longint t;
        logic [5:0] a;
        logic [31:0] wd, d_before;
        for (int it = 0; it < 40; it++) begin
            mem_lat  = int'($urandom_range(1, 4));
            kind     = int'($urandom_range(0, 2));
            a        = 6'($urandom);
            wd       = $urandom;
            d_before = D_READDATA;
            base     = log_n;
            if (kind == 2) begin
                do_inst(a, lat, t);
                exp_lat = 4 * (3 + mem_lat);
                n_checks++;
                if (I_READDATA !== exp_block(a) || log_addr[base + 3] !== imap(a, 3)) begin
                    n_fail++;
                    $display("FAIL rnd_inst it%0d: got %h addr3 %0d want %h %0d", it,
                             I_READDATA, log_addr[base + 3], exp_block(a), imap(a, 3));
                end
            end else begin
                do_data(kind == 1, a, wd, lat, t);
                exp_lat = 3 + mem_lat;
                if (kind == 1) ref_mem[dmap(a)] = wd;
                n_checks++;
                if (D_READDATA !== ((kind == 1) ? d_before : ref_mem[dmap(a)]) ||
                    log_addr[base] !== dmap(a)) begin
                    n_fail++;
                    $display("FAIL rnd_data it%0d kind %0d: got %h addr %0d want %h %0d", it, kind,
                             D_READDATA, log_addr[base], (kind == 1) ? d_before : ref_mem[dmap(a)],
                             dmap(a));
                end
            end
            n_checks++;
            if (lat !== exp_lat) begin
                n_fail++;
                $display("FAIL rnd_latency it%0d: got %0d want %0d", it, lat, exp_lat);
            end
        end
        n_checks++;
        if (stab_err !== 0) begin
            n_fail++;
            $display("FAIL rnd_bus_stable: got %0d unstable edges want 0", stab_err);
        end
    endtask

    initial begin
        #1 RESET_N = 1'b0;
        #1;
        test_reset();
        @(posedge CLK);
        #1;
        for (int i = 0; i < 512; i++) preload(9'(i), $urandom);
        RESET_N = 1'b1;
        tick();
        test_data_read();
        test_inst_refill();
        test_arbitration();
        test_write_during_burst();
        test_reset_mid_burst();
        test_backpressure();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
